// File: rtl/answer_ctrl.sv
// Round sequencer for the factorization answer-entry path: owns the three answer digits,
// turns button pulses into edits/selection/submission and tracks wrong attempts.
//
// state   | meaning
// S_IDLE  | after reset, waiting for the first start
// S_ENTRY | digits editable, submit accepted when any digit is nonzero
// S_CHECK | digits frozen, waiting out the checker latency before sampling the result
// S_WIN   | correct answer seen, held until the next start
// S_LOCK  | out of attempts, held until the next start
module answer_ctrl #(
  parameter int DIGIT_MAX   = 9,
  parameter int MAX_TRIES   = 3,
  parameter int RESULT_WAIT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_next,
  input  logic       i_btn_submit,
  input  logic [1:0] i_result,
  output logic [3:0] o_count1,
  output logic [3:0] o_count2,
  output logic [3:0] o_count3,
  output logic [1:0] o_sel,
  output logic [1:0] o_tries,
  output logic       o_busy,
  output logic       o_wrong,
  output logic       o_win,
  output logic       o_locked
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  localparam int              CW        = $clog2(RESULT_WAIT);
  localparam logic [3:0]      DMAX      = 4'(DIGIT_MAX);
  localparam logic [2:0]      TMAX      = 3'(MAX_TRIES);
  localparam logic [CW-1:0]   WAIT_LOAD = CW'(RESULT_WAIT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_count1;
  logic [3:0]    r_count2;
  logic [3:0]    r_count3;
  logic [1:0]    r_sel;
  logic [1:0]    r_tries;
  logic [CW-1:0] r_wait;
  logic          r_wrong;

  logic       w_in_entry;
  logic       w_any_digit;
  logic       w_submit_ok;
  logic       w_next;
  logic       w_edit;
  logic       w_sample;
  logic       w_correct;
  logic       w_last_try;
  logic [3:0] w_cur;
  logic [3:0] w_cur_inc;
  logic [3:0] w_cur_dec;
  logic [3:0] w_edit_val;
  logic [1:0] w_sel_nxt;

  // Action decode in ENTRY; a submit pulse claims the cycle even when it is ignored.
  assign w_in_entry  = (r_state == S_ENTRY);
  assign w_any_digit = (r_count1 != 4'd0) || (r_count2 != 4'd0) || (r_count3 != 4'd0);
  assign w_submit_ok = w_in_entry && i_btn_submit && w_any_digit;
  assign w_next      = w_in_entry && !i_btn_submit && i_btn_next;
  assign w_edit      = w_in_entry && !i_btn_submit && !i_btn_next && (i_btn_up || i_btn_down);
  assign w_sample    = (r_state == S_CHECK) && (r_wait == '0);
  assign w_correct   = (i_result == 2'b11);
  assign w_last_try  = (({1'b0, r_tries} + 3'd1) == TMAX);

  always_comb begin
    w_cur = r_count1;
    case (r_sel)
      2'd1:    w_cur = r_count2;
      2'd2:    w_cur = r_count3;
      default: w_cur = r_count1;
    endcase
  end

  assign w_cur_inc  = (w_cur == DMAX) ? 4'd0 : w_cur + 4'd1;
  assign w_cur_dec  = (w_cur == 4'd0) ? DMAX : w_cur - 4'd1;
  assign w_edit_val = i_btn_up ? w_cur_inc : w_cur_dec;
  assign w_sel_nxt  = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = S_ENTRY;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_ENTRY: if (w_submit_ok) w_state_nxt = S_CHECK;
        S_CHECK: begin
          if (w_sample) begin
            if (w_correct)       w_state_nxt = S_WIN;
            else if (w_last_try) w_state_nxt = S_LOCK;
            else                 w_state_nxt = S_ENTRY;
          end
        end
        S_WIN:   w_state_nxt = S_WIN;
        S_LOCK:  w_state_nxt = S_LOCK;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count1 <= 4'd0;
      r_count2 <= 4'd0;
      r_count3 <= 4'd0;
      r_sel    <= 2'd0;
      r_tries  <= 2'd0;
      r_wait   <= '0;
      r_wrong  <= 1'b0;
    end else begin
      r_wrong <= 1'b0;
      if (i_start) begin
        // Clearing the wait counter also drops any result still in flight.
        r_count1 <= 4'd0;
        r_count2 <= 4'd0;
        r_count3 <= 4'd0;
        r_sel    <= 2'd0;
        r_tries  <= 2'd0;
        r_wait   <= '0;
      end else begin
        if (w_edit) begin
          case (r_sel)
            2'd1:    r_count2 <= w_edit_val;
            2'd2:    r_count3 <= w_edit_val;
            default: r_count1 <= w_edit_val;
          endcase
        end
        if (w_next) r_sel <= w_sel_nxt;
        if (w_submit_ok) begin
          r_wait <= WAIT_LOAD;
        end else if ((r_state == S_CHECK) && (r_wait != '0)) begin
          r_wait <= r_wait - CW'(1);
        end
        if (w_sample && !w_correct) begin
          r_tries <= r_tries + 2'd1;
          r_wrong <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_count1 = r_count1;
    o_count2 = r_count2;
    o_count3 = r_count3;
    o_sel    = r_sel;
    o_tries  = r_tries;
    o_wrong  = r_wrong;
    o_busy   = (r_state == S_CHECK);
    o_win    = (r_state == S_WIN);
    o_locked = (r_state == S_LOCK);
  end

endmodule

// File: tb/tb_answer_ctrl.sv
// Scoreboard bench for answer_ctrl: directed button vectors push hand-computed output
// snapshots; a monitor pops one per clock and compares against the DUT.
module tb_answer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_start = 1'b0, i_up = 1'b0, i_down = 1'b0, i_next = 1'b0, i_submit = 1'b0;
  logic [1:0] i_result;
  logic [3:0] c1, c2, c3;
  logic [1:0] sel, tries;
  logic       busy, wrong, win, locked;

  logic [1:0] res_s1, res_s2;
  logic [19:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  answer_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .i_btn_up(i_up), .i_btn_down(i_down), .i_btn_next(i_next), .i_btn_submit(i_submit),
    .i_result(i_result),
    .o_count1(c1), .o_count2(c2), .o_count3(c3), .o_sel(sel), .o_tries(tries),
    .o_busy(busy), .o_wrong(wrong), .o_win(win), .o_locked(locked)
  );

  // Behavioural 2-stage checker; the answer is 3,5,9 and an all-zero input holds the output.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_s1 <= 2'b00;
      res_s2 <= 2'b00;
    end else begin
      if ({c1, c2, c3} != 12'd0)
        res_s1 <= (c1 == 4'd3 && c2 == 4'd5 && c3 == 4'd9) ? 2'b11 : 2'b00;
      res_s2 <= res_s1;
    end
  end
  assign i_result = res_s2;

  function automatic logic [19:0] snap();
    return {c1, c2, c3, sel, tries, busy, wrong, win, locked};
  endfunction

  task automatic compare(input string nm, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got c=%h%h%h sel=%0d tries=%0d busy=%b wrong=%b win=%b lock=%b, want c=%h%h%h sel=%0d tries=%0d busy=%b wrong=%b win=%b lock=%b",
               nm, act[19:16], act[15:12], act[11:8], act[7:6], act[5:4], act[3], act[2], act[1], act[0],
               exp[19:16], exp[15:12], exp[11:8], exp[7:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) compare(name_q.pop_front(), snap(), exp_q.pop_front());
  end

  // One clock of stimulus plus the outputs expected right after the next rising edge.
  task automatic cyc(input logic st, up, dn, nx, sb,
                     input logic [3:0] e1, e2, e3, input logic [1:0] es, et,
                     input logic eb, ew, en, el, input string nm);
    @(negedge clk);
    i_start = st; i_up = up; i_down = dn; i_next = nx; i_submit = sb;
    exp_q.push_back({e1, e2, e3, es, et, eb, ew, en, el});
    name_q.push_back(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #3 compare("reset_state", snap(), 20'd0);
    @(negedge clk) rst_n = 1'b1;

    cyc(0,1,0,0,0, 0,0,0, 0,0, 0,0,0,0, "idle_up_ignored");
    cyc(1,0,0,0,0, 0,0,0, 0,0, 0,0,0,0, "start");
    cyc(0,0,1,0,0, 9,0,0, 0,0, 0,0,0,0, "down_wrap");
    cyc(0,1,0,0,0, 0,0,0, 0,0, 0,0,0,0, "up_wrap");
    cyc(0,0,0,1,0, 0,0,0, 1,0, 0,0,0,0, "next_1");
    cyc(0,0,0,1,0, 0,0,0, 2,0, 0,0,0,0, "next_2");
    cyc(0,0,0,1,0, 0,0,0, 0,0, 0,0,0,0, "next_0");
    for (int k = 1; k <= 3; k++) cyc(0,1,0,0,0, 4'(k),0,0, 0,0, 0,0,0,0, "enter_d1");
    cyc(0,0,0,1,0, 3,0,0, 1,0, 0,0,0,0, "sel_d2");
    for (int k = 1; k <= 5; k++) cyc(0,1,0,0,0, 3,4'(k),0, 1,0, 0,0,0,0, "enter_d2");
    cyc(0,0,0,1,0, 3,5,0, 2,0, 0,0,0,0, "sel_d3");
    cyc(0,0,1,0,0, 3,5,9, 2,0, 0,0,0,0, "enter_d3");
    cyc(0,0,0,0,1, 3,5,9, 2,0, 1,0,0,0, "win_busy_1");
    cyc(0,1,0,0,0, 3,5,9, 2,0, 1,0,0,0, "win_busy_2");
    cyc(0,0,0,0,0, 3,5,9, 2,0, 0,0,1,0, "win_set");
    cyc(0,1,0,0,0, 3,5,9, 2,0, 0,0,1,0, "win_hold_up");
    cyc(0,0,0,1,1, 3,5,9, 2,0, 0,0,1,0, "win_hold_sub");

    cyc(1,0,0,0,0, 0,0,0, 0,0, 0,0,0,0, "start_from_win");
    cyc(0,1,0,0,0, 1,0,0, 0,0, 0,0,0,0, "w_d1");
    cyc(0,0,0,1,0, 1,0,0, 1,0, 0,0,0,0, "w_sel2");
    cyc(0,1,0,0,0, 1,1,0, 1,0, 0,0,0,0, "w_d2");
    cyc(0,0,0,1,0, 1,1,0, 2,0, 0,0,0,0, "w_sel3");
    cyc(0,1,0,0,0, 1,1,1, 2,0, 0,0,0,0, "w_d3");
    cyc(0,0,0,0,1, 1,1,1, 2,0, 1,0,0,0, "try1_busy");
    cyc(0,0,0,0,0, 1,1,1, 2,0, 1,0,0,0, "try1_wait");
    cyc(0,0,0,0,0, 1,1,1, 2,1, 0,1,0,0, "try1_wrong");
    cyc(0,0,0,0,0, 1,1,1, 2,1, 0,0,0,0, "wrong_one_cycle");
    cyc(0,0,0,0,1, 1,1,1, 2,1, 1,0,0,0, "try2_busy");
    cyc(0,0,0,0,0, 1,1,1, 2,1, 1,0,0,0, "try2_wait");
    cyc(0,0,0,0,0, 1,1,1, 2,2, 0,1,0,0, "try2_wrong");
    cyc(0,0,0,0,1, 1,1,1, 2,2, 1,0,0,0, "try3_immediate");
    cyc(0,0,0,0,0, 1,1,1, 2,2, 1,0,0,0, "try3_wait");
    cyc(0,0,0,0,0, 1,1,1, 2,3, 0,1,0,1, "lock");
    cyc(0,1,0,0,1, 1,1,1, 2,3, 0,0,0,1, "lock_hold");
    cyc(1,0,0,0,0, 0,0,0, 0,0, 0,0,0,0, "start_from_lock");

    cyc(0,0,0,0,1, 0,0,0, 0,0, 0,0,0,0, "zero_submit");
    cyc(0,1,0,0,0, 1,0,0, 0,0, 0,0,0,0, "z_d1");
    cyc(0,0,0,1,1, 1,0,0, 0,0, 1,0,0,0, "submit_beats_next");
    cyc(0,0,0,0,0, 1,0,0, 0,0, 1,0,0,0, "sbn_wait");
    cyc(0,0,0,0,0, 1,0,0, 0,1, 0,1,0,0, "sbn_wrong");
    cyc(0,0,0,0,1, 1,0,0, 0,1, 1,0,0,0, "abort_busy");
    cyc(1,0,0,0,1, 0,0,0, 0,0, 0,0,0,0, "start_in_check");
    cyc(0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0, "no_stale_wrong");
    cyc(0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0, "still_entry");

    cyc(0,1,0,0,0, 1,0,0, 0,0, 0,0,0,0, "r_d1");
    cyc(0,0,0,0,1, 1,0,0, 0,0, 1,0,0,0, "r_busy");
    @(negedge clk);
    i_start = 0; i_up = 0; i_down = 0; i_next = 0; i_submit = 0;
    #2 rst_n = 1'b0;
    #1 compare("async_reset_mid_check", snap(), 20'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc(0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0, "post_reset_idle");
    cyc(0,1,0,0,0, 0,0,0, 0,0, 0,0,0,0, "post_reset_up");

    @(negedge clk);
    i_start = 0; i_up = 0; i_down = 0; i_next = 0; i_submit = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
